// File: rtl/scu_pkg.sv
// Shared constants and drain state encoding for the SCU output drain.
// Holds A_BITS default, OC geometry, beat-counter width and state enum.
package scu_pkg;
  localparam int A_BITS_DEF = 12;
  localparam int OC_LEN = 16;
  localparam int NUM_OC = 3;
  localparam int BEAT_W = $clog2(OC_LEN);
  localparam int CH_W = 2;

  typedef enum logic [0:0] {
    DRAIN_IDLE   = 1'b0,
    DRAIN_STREAM = 1'b1
  } drain_state_e;
endpackage

// File: rtl/scu_drain_lane_mux.sv
// Combinational selector: picks LANES values from the snapshot.
// Ports: snap (flat 48 values), ch, beat -> data (lane 0 in low bits).
module scu_drain_lane_mux
  import scu_pkg::*;
#(
  parameter int A_BITS = A_BITS_DEF,
  parameter int LANES  = 4
) (
  input  logic [NUM_OC*OC_LEN*A_BITS-1:0] snap,
  input  logic [CH_W-1:0]                 ch,
  input  logic [BEAT_W-1:0]               beat,
  output logic [LANES*A_BITS-1:0]         data
);
  localparam int NVAL = NUM_OC * OC_LEN;

  always_comb begin
    data = '0;
    for (int l = 0; l < LANES; l++) begin
      int idx;
      idx = int'(ch) * OC_LEN + int'(beat) * LANES + l;
      // ch can step past the last channel once a conv tile ends
      if (idx < NVAL)
        data[l*A_BITS +: A_BITS] = snap[idx*A_BITS +: A_BITS];
    end
  end
endmodule

// File: rtl/scu_out_drain.sv
// SCU drain: snapshots OC0..OC2 on tile_done, streams LANES-wide beats.
// Ports: tile/mode in, scu_clear/busy/overflow, out_* valid/ready stream.
// Optional ReLU clamp at snapshot: define SCU_DRAIN_RELU_EN.
module scu_out_drain
  import scu_pkg::*;
#(
  parameter int A_BITS = A_BITS_DEF,
  parameter int LANES  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic                      tile_done,
  input  logic [OC_LEN*A_BITS-1:0]  oc0,
  input  logic [OC_LEN*A_BITS-1:0]  oc1,
  input  logic [OC_LEN*A_BITS-1:0]  oc2,
  output logic                      scu_clear,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*A_BITS-1:0]   out_data,
  output logic [1:0]                out_ch,
  output logic                      out_last,
  output logic                      overflow
);
  localparam int SNAP_W = NUM_OC * OC_LEN * A_BITS;
  localparam int BPC = OC_LEN / LANES;
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BPC - 1);
  localparam logic [CH_W-1:0] CH_MAX = CH_W'(NUM_OC - 1);

  drain_state_e state_q, state_d;
  logic [SNAP_W-1:0] snap_q, snap_d, snap_in;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic mode_q, mode_d;
  logic clear_q, clear_d;
  logic ovf_q, ovf_d;
  logic [LANES*A_BITS-1:0] mux_data;
  logic streaming, is_last, accept;

  always_comb begin
    snap_in = {oc2, oc1, oc0};
`ifdef SCU_DRAIN_RELU_EN
    for (int i = 0; i < NUM_OC * OC_LEN; i++)
      if (snap_in[i*A_BITS + A_BITS - 1])
        snap_in[i*A_BITS +: A_BITS] = '0;
`endif
  end

  assign streaming = (state_q == DRAIN_STREAM);
  assign accept = streaming && out_ready;
  assign is_last = (beat_q == BEAT_MAX) &&
                   (ch_q == (mode_q ? CH_MAX : '0));

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    ch_d    = ch_q;
    beat_d  = beat_q;
    mode_d  = mode_q;
    clear_d = 1'b0;
    ovf_d   = ovf_q;
    unique case (state_q)
      DRAIN_IDLE: begin
        if (tile_done) begin
          snap_d  = snap_in;
          mode_d  = mode;
          ch_d    = '0;
          beat_d  = '0;
          clear_d = 1'b1;
          state_d = DRAIN_STREAM;
        end
      end
      DRAIN_STREAM: begin
        if (accept) begin
          if (beat_q == BEAT_MAX) begin
            beat_d = '0;
            ch_d   = ch_q + CH_W'(1);
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
        // a tile_done is only absorbed when the final beat leaves
        if (accept && is_last) begin
          if (tile_done) begin
            snap_d  = snap_in;
            mode_d  = mode;
            ch_d    = '0;
            beat_d  = '0;
            clear_d = 1'b1;
          end else begin
            state_d = DRAIN_IDLE;
          end
        end else if (tile_done) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = DRAIN_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DRAIN_IDLE;
      snap_q  <= '0;
      ch_q    <= '0;
      beat_q  <= '0;
      mode_q  <= 1'b0;
      clear_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      ch_q    <= ch_d;
      beat_q  <= beat_d;
      mode_q  <= mode_d;
      clear_q <= clear_d;
      ovf_q   <= ovf_d;
    end
  end

  scu_drain_lane_mux #(
    .A_BITS(A_BITS),
    .LANES (LANES)
  ) u_mux (
    .snap(snap_q),
    .ch  (ch_q),
    .beat(beat_q),
    .data(mux_data)
  );

  assign out_valid = streaming;
  assign busy      = streaming;
  assign out_data  = streaming ? mux_data : '0;
  assign out_ch    = streaming ? ch_q : '0;
  assign out_last  = streaming && is_last;
  assign scu_clear = clear_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_scu_out_drain.sv
// Scoreboard bench for scu_out_drain with a queue-based beat model.
// Honours SCU_DRAIN_RELU_EN in the reference model.
module tb_scu_out_drain;
  localparam int AB = 12;
  localparam int L = 4;

  typedef struct {
    logic [L*AB-1:0] data;
    logic [1:0]      ch;
    logic            last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n, mode, tile_done, out_ready;
  logic [16*AB-1:0] oc0, oc1, oc2;
  logic scu_clear, busy, out_valid, out_last, overflow;
  logic [L*AB-1:0] out_data;
  logic [1:0] out_ch;
  logic [AB-1:0] ocv [3][16];

  beat_t exp_q[$];
  beat_t mb;
  int rem;
  bit exp_ovf, exp_clear;
  int checks, errors;

  always #5 clk = ~clk;

  always_comb begin
    oc0 = '0;
    oc1 = '0;
    oc2 = '0;
    for (int i = 0; i < 16; i++) begin
      oc0[i*AB +: AB] = ocv[0][i];
      oc1[i*AB +: AB] = ocv[1][i];
      oc2[i*AB +: AB] = ocv[2][i];
    end
  end

  scu_out_drain #(.A_BITS(AB), .LANES(L)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .tile_done(tile_done),
    .oc0(oc0), .oc1(oc1), .oc2(oc2),
    .scu_clear(scu_clear), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .out_last(out_last), .overflow(overflow)
  );

  function automatic logic [AB-1:0] relu(input logic [AB-1:0] v);
`ifdef SCU_DRAIN_RELU_EN
    return v[AB-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, act, expv, $time);
    end
  endtask

  // Expected beats: used channels flattened, then cut into LANES chunks.
  task automatic push_tile(input bit m);
    logic [AB-1:0] flat[$];
    beat_t b;
    int nb;
    flat = {};
    for (int c = 0; c < (m ? 3 : 1); c++)
      for (int i = 0; i < 16; i++)
        flat.push_back(relu(ocv[c][i]));
    nb = flat.size() / L;
    for (int k = 0; k < nb; k++) begin
      b.data = '0;
      for (int l = 0; l < L; l++)
        b.data[l*AB +: AB] = flat[k*L + l];
      b.ch = 2'((k * L) / 16);
      b.last = (k == nb - 1);
      exp_q.push_back(b);
    end
    rem = nb;
  endtask

  task automatic cyc(input bit td, input bit rdy);
    bit acc, take;
    tile_done = td;
    out_ready = rdy;
    @(negedge clk);
    acc = (rem > 0) && rdy;
    take = td && (rem == 0 || (acc && rem == 1));
    if (td && !take) exp_ovf = 1'b1;
    if (acc) rem--;
    exp_clear = take;
    if (take) push_tile(mode);
    @(posedge clk);
    #1;
    tile_done = 1'b0;
    chk("busy", 64'(busy), 64'(rem > 0));
    chk("valid", 64'(out_valid), 64'(rem > 0));
    chk("scu_clear", 64'(scu_clear), 64'(exp_clear));
    chk("overflow", 64'(overflow), 64'(exp_ovf));
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && rem > 0; i++) cyc(1'b0, 1'b1);
    if (rem > 0) begin
      errors++;
      $display("FAIL drain_timeout rem=%0d want=0", rem);
    end
  endtask

  task automatic ramp();
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < 16; i++)
        ocv[c][i] = AB'(16 * c + i);
  endtask

  always @(negedge clk) begin : monitor
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_extra got=%0h want=none", out_data);
      end else begin
        mb = exp_q.pop_front();
        if (out_data !== mb.data || out_ch !== mb.ch ||
            out_last !== mb.last) begin
          errors++;
          $display("FAIL beat got=%0h/%0d/%0b want=%0h/%0d/%0b",
                   out_data, out_ch, out_last, mb.data, mb.ch, mb.last);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rem = 0;
    exp_ovf = 0;
    exp_clear = 0;
    rst_n = 1'b0;
    mode = 1'b1;
    tile_done = 1'b0;
    out_ready = 1'b0;
    ramp();
    #12;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // conv tile, ready held high
    mode = 1'b1;
    cyc(1'b1, 1'b1);
    chk("first_beat", 64'(out_data), 64'h003_002_001_000);
    drain();
    cyc(1'b0, 1'b1);

    // deconv tile
    mode = 1'b0;
    cyc(1'b1, 1'b1);
    drain();
    cyc(1'b0, 1'b1);

    // backpressure 1,0,0,1
    mode = 1'b1;
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 60 && rem > 0; i++)
      cyc(1'b0, (i % 4 == 0) || (i % 4 == 3));
    drain();

    // back-to-back: tile_done with the accepted final beat
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 40 && rem > 1; i++) cyc(1'b0, 1'b1);
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < 16; i++)
        ocv[c][i] = AB'(100 + 16 * c + i);
    cyc(1'b1, 1'b1);
    drain();
    cyc(1'b0, 1'b0);

    // ReLU corner values
    mode = 1'b0;
    ocv[0][0] = 12'hFFB;
    ocv[0][1] = 12'h007;
    cyc(1'b1, 1'b0);
`ifdef SCU_DRAIN_RELU_EN
    chk("relu_lanes", 64'(out_data[2*AB-1:0]), 64'h007_000);
`else
    chk("raw_lanes", 64'(out_data[2*AB-1:0]), 64'h007_FFB);
`endif
    drain();

    // overflow: tile_done while beat 5 is presented
    ramp();
    mode = 1'b1;
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1);
    ocv[0][0] = 12'h555;
    cyc(1'b1, 1'b1);
    drain();

    // reset while beat 3 is presented
    ramp();
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(out_valid), 64'(0));
    chk("mrst_busy", 64'(busy), 64'(0));
    chk("mrst_data", 64'(out_data), 64'(0));
    chk("mrst_ch", 64'(out_ch), 64'(0));
    chk("mrst_last", 64'(out_last), 64'(0));
    chk("mrst_ovf", 64'(overflow), 64'(0));
    exp_q.delete();
    rem = 0;
    exp_ovf = 0;
    exp_clear = 0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b1, 1'b1);
    drain();

    // random traffic
    for (int n = 0; n < 500; n++) begin
      for (int c = 0; c < 3; c++)
        for (int i = 0; i < 16; i++)
          ocv[c][i] = AB'($urandom);
      mode = 1'($urandom);
      cyc(($urandom % 6) == 0, ($urandom % 3) != 0);
    end
    drain();
    cyc(1'b0, 1'b1);
    chk("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/scu_out_drain.md
# scu_out_drain

Downstream drain stage for the sparse compute unit (SCU). When a tile finishes, the block snapshots the SCU output channels OC0..OC2 (16 signed A_bits values each) into a local buffer and pulses the SCU accumulator clear. It then streams the snapshot as LANES-wide packed beats over a valid/ready interface to the output buffer writer, so the SCU can start the next tile while the previous one drains.

## Interface
- A_BITS, 12, width of one output value (matches SCU OC width)
- LANES, 4, values per output beat; legal values are 1, 2, 4, 8, 16
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- mode  input  1  1 = Rfconv (OC0..OC2 valid); 0 = Rfdeconv (OC0 only); sampled at snapshot
- tile_done  input  1  one-cycle pulse: SCU accumulators final this cycle
- oc0, oc1, oc2  input  signed [A_BITS-1:0] x16 each  SCU output channels
- scu_clear  output  1  one-cycle clear pulse to the SCU
- busy  output  1  high while a snapshot is held and not fully drained
- out_valid  output  1  beat available
- out_ready  input  1  downstream accepts beat
- out_data  output  LANES*A_BITS  packed beat; lane 0 in bits [A_BITS-1:0]
- out_ch  output  2  channel of the current beat (0..2)
- out_last  output  1  final beat of the tile
- overflow  output  1  sticky; a tile_done was dropped

## Operation
- FSM states: IDLE, STREAM.
- IDLE:
  - tile_done=1 → copy all 48 values into the snapshot buffer, latch mode, reset beat counters, go to STREAM.
- STREAM:
  - Beat order: channel 0 elements 0..LANES-1, then LANES..2*LANES-1, and so on through element 15. Then channel 1, then channel 2.
  - Element e of a beat occupies lane e mod LANES.
  - Beats per tile: mode=1 gives 3*16/LANES (12 at default); mode=0 gives 16/LANES (4 at default).
  - A beat advances only on out_valid && out_ready.
  - out_last=1 only on the final beat.
  - Accepted final beat with no tile_done in the same cycle → IDLE.
- Simultaneous events:
  - tile_done in the same cycle as the accepted final beat: the new snapshot is taken and the FSM stays in STREAM with the counters reset. This is not an overflow.
  - tile_done in STREAM otherwise: the pulse is ignored, the snapshot is kept intact, and overflow is set. overflow clears only on reset.
- scu_clear is high for exactly the one cycle after each accepted snapshot.
- busy = (state == STREAM).
- While out_valid && !out_ready, out_data, out_ch and out_last hold stable.
- Values pass through unmodified apart from the optional ReLU. There is no width change.

## Timing
- Reset values: scu_clear=0, busy=0, out_valid=0, out_data=0, out_ch=0, out_last=0, overflow=0, FSM in IDLE, snapshot buffer zero.
- tile_done is sampled at edge t. The snapshot registers at t.
- In cycle t+1: scu_clear=1, busy=1, out_valid=1, and the first beat is on out_data. Latency is 1 cycle.
- With out_ready held high, one beat per cycle. A tile drains in 12 cycles (mode=1) or 4 cycles (mode=0).
- out_valid drops in the cycle after the final beat is accepted, unless a back-to-back snapshot was taken.
- rst_n asserted mid-stream: the snapshot is discarded and no further beats are issued. All outputs return to reset values asynchronously.

## Configuration
- SCU_DRAIN_RELU_EN
  - Defined: each value is clamped to 0 if negative at snapshot time. The output value range is [0, 2^(A_BITS-1)-1].
  - Undefined: raw two's-complement values are forwarded.

## Structure
- Shared package scu_pkg holds:
  - A_BITS default
  - OC_LEN=16
  - NUM_OC=3
  - beat-counter width
  - the drain state enum (IDLE, STREAM)
- One sub-module, scu_drain_lane_mux: selects LANES values from the snapshot by (channel, beat index). It is purely combinational. The FSM and the snapshot buffer stay in the top level.

## Test plan
- Conv snapshot:
  - Stimulus: mode=1; oc0[i]=i, oc1[i]=16+i, oc2[i]=32+i; tile_done pulse; out_ready=1.
  - Response: 12 beats in 12 consecutive cycles. First out_data = {3,2,1,0}. out_ch goes 0,0,0,0,1,…,2. out_last on beat 12. scu_clear high one cycle at t+1.
- Deconv:
  - Stimulus: mode=0, same data.
  - Response: 4 beats on channel 0 only, with out_last on beat 4. busy drops after that.
- Backpressure:
  - Stimulus: out_ready toggled 1,0,0,1,…
  - Response: out_data, out_ch and out_last hold stable while stalled. No beat is lost or duplicated.
- Overflow and back-to-back:
  - Stimulus A: tile_done on beat 5 of a conv tile.
  - Response A: overflow=1 and the stream continues unchanged.
  - Stimulus B: tile_done coincident with the accepted last beat.
  - Response B: the new tile starts next cycle and overflow stays 0.
- ReLU:
  - Stimulus: oc0[0]=-5 (0xFFB), oc0[1]=7.
  - Response with SCU_DRAIN_RELU_EN defined: lanes read 0 and 7.
  - Response without the macro: lanes read 0xFFB and 7.
- Reset mid-stream:
  - Stimulus: rst_n low during beat 3.
  - Response: all outputs return to 0 immediately and the FSM is in IDLE. The next tile_done starts a fresh stream.
